// File: rtl/line_cache_pkg.sv
// Shared state encoding and address-field helpers for the multi-line write-back cache.
// Fields come from an address of up to 32 bits split as {tag, index, offset}.
package line_cache_pkg;

    localparam logic [2:0] StIdle  = 3'd0;
    localparam logic [2:0] StHit   = 3'd1;
    localparam logic [2:0] StEvict = 3'd2;
    localparam logic [2:0] StFill  = 3'd3;
    localparam logic [2:0] StMerge = 3'd4;
    localparam logic [2:0] StWthru = 3'd5;
    localparam logic [2:0] StFlush = 3'd6;
    localparam logic [2:0] StFlWb  = 3'd7;

    function automatic logic [31:0] addr_field(input logic [31:0] addr,
                                               input int unsigned lsb,
                                               input int unsigned width);
        logic [31:0] mask;
        mask = (width >= 32) ? '1 : ((32'd1 << width) - 32'd1);
        return (addr >> lsb) & mask;
    endfunction

    function automatic logic [31:0] addr_offset(input logic [31:0] addr,
                                                input int unsigned off_w);
        return addr_field(addr, 0, off_w);
    endfunction

    function automatic logic [31:0] addr_index(input logic [31:0] addr,
                                               input int unsigned off_w,
                                               input int unsigned idx_w);
        return addr_field(addr, off_w, idx_w);
    endfunction

    function automatic logic [31:0] addr_tag(input logic [31:0] addr,
                                             input int unsigned off_w,
                                             input int unsigned idx_w,
                                             input int unsigned tag_w);
        return addr_field(addr, off_w + idx_w, tag_w);
    endfunction

endpackage

// File: rtl/line_cache_tags.sv
// Per-line valid/dirty bits (async cleared) and tag store, with one lookup and one update port.
// Lookup and update share the same index; the tag store is deliberately not reset.
module line_cache_tags #(
    parameter int unsigned NUM_LINES = 16,
    parameter int unsigned IDX_W     = 4,
    parameter int unsigned TAG_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IDX_W-1:0] idx,
    output logic             lk_valid,
    output logic             lk_dirty,
    output logic [TAG_W-1:0] lk_tag,
    input  logic             upd_en,
    input  logic             upd_valid,
    input  logic             upd_dirty,
    input  logic             upd_tag_en,
    input  logic [TAG_W-1:0] upd_tag
);

    logic [NUM_LINES-1:0] valid_q;
    logic [NUM_LINES-1:0] dirty_q;
    logic [TAG_W-1:0]     tag_q [NUM_LINES];

    assign lk_valid = valid_q[idx];
    assign lk_dirty = dirty_q[idx];
    assign lk_tag   = tag_q[idx];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (upd_en) begin
            valid_q[idx] <= upd_valid;
            dirty_q[idx] <= upd_dirty;
        end
    end

    always_ff @(posedge clk) begin
        if (upd_tag_en) begin
            tag_q[idx] <= upd_tag;
        end
    end

endmodule

// File: rtl/line_cache.sv
// Direct-mapped write-back cache between a 32-bit word port and line-granular memory.
// Supports dirty-victim eviction, per-request write-through and a write-back-all flush.
module line_cache
    import line_cache_pkg::*;
#(
    parameter int unsigned NUM_LINES  = 16,
    parameter int unsigned LINE_WORDS = 16,
    parameter int unsigned ADDR_W     = 24
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     r_en,
    input  logic                     w_en,
    input  logic                     write_through,
    input  logic                     flush,
    input  logic [ADDR_W-1:0]        addr,
    input  logic [31:0]              data_store,
    output logic [31:0]              data_load,
    output logic                     done,
    output logic                     cache_hit,
    input  logic [LINE_WORDS*32-1:0] line_read,
    output logic [LINE_WORDS*32-1:0] line_store,
    output logic                     mem_r_en,
    output logic                     mem_w_en,
    input  logic                     mem_ready,
    input  logic                     mem_done,
    output logic [ADDR_W-1:0]        mem_addr
);

    localparam int unsigned OFF_W = $clog2(LINE_WORDS);
    localparam int unsigned IDX_W = $clog2(NUM_LINES);
    localparam int unsigned TAG_W = ADDR_W - IDX_W - OFF_W;
    localparam int unsigned LINE_W = LINE_WORDS * 32;

    logic [2:0]        state_q, state_d;
    logic [IDX_W-1:0]  flush_cnt_q, flush_cnt_d;
    logic              done_q, done_d;
    logic              hit_q, hit_d;
    logic [31:0]       data_load_q, data_load_d;
    logic              mem_r_en_q, mem_r_en_d;
    logic              mem_w_en_q, mem_w_en_d;
    logic              orig_hit_q, orig_hit_d;
    logic              op_wr_q, op_wr_d;
    logic              op_wt_q, op_wt_d;

    logic [TAG_W-1:0]  req_tag;
    logic [IDX_W-1:0]  req_idx, lk_idx;
    logic [OFF_W-1:0]  req_off;
    logic              lk_valid, lk_dirty, hit;
    logic [TAG_W-1:0]  lk_tag;
    logic              upd_en, upd_valid, upd_dirty, upd_tag_en;
    logic [TAG_W-1:0]  upd_tag;
    logic              line_we, word_we;
    logic [LINE_W-1:0] data_q [NUM_LINES];
    logic [LINE_W-1:0] cur_line;
    logic [31:0]       cur_word;
    logic              flushing;

    assign req_tag = TAG_W'(addr_tag(32'(addr), OFF_W, IDX_W, TAG_W));
    assign req_idx = IDX_W'(addr_index(32'(addr), OFF_W, IDX_W));
    assign req_off = OFF_W'(addr_offset(32'(addr), OFF_W));

    assign flushing = (state_q == StFlush) || (state_q == StFlWb);
    assign lk_idx   = flushing ? flush_cnt_q : req_idx;
    assign cur_line = data_q[lk_idx];
    assign cur_word = cur_line[{req_off, 5'b0} +: 32];
    assign hit      = lk_valid && (lk_tag == req_tag);

    line_cache_tags #(
        .NUM_LINES(NUM_LINES),
        .IDX_W    (IDX_W),
        .TAG_W    (TAG_W)
    ) u_tags (
        .clk       (clk),
        .rst_n     (rst_n),
        .idx       (lk_idx),
        .lk_valid  (lk_valid),
        .lk_dirty  (lk_dirty),
        .lk_tag    (lk_tag),
        .upd_en    (upd_en),
        .upd_valid (upd_valid),
        .upd_dirty (upd_dirty),
        .upd_tag_en(upd_tag_en),
        .upd_tag   (upd_tag)
    );

    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        done_d      = 1'b0;
        hit_d       = 1'b0;
        data_load_d = data_load_q;
        mem_r_en_d  = mem_r_en_q;
        mem_w_en_d  = mem_w_en_q;
        orig_hit_d  = orig_hit_q;
        op_wr_d     = op_wr_q;
        op_wt_d     = op_wt_q;
        upd_en      = 1'b0;
        upd_valid   = lk_valid;
        upd_dirty   = lk_dirty;
        upd_tag_en  = 1'b0;
        upd_tag     = lk_tag;
        line_we     = 1'b0;
        word_we     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (w_en || r_en) begin
                    op_wr_d    = w_en;
                    op_wt_d    = w_en && write_through;
                    orig_hit_d = hit;
                    if (hit && w_en && write_through) begin
                        // Merge now so WTHRU can stream the updated line straight out.
                        word_we   = 1'b1;
                        upd_en    = 1'b1;
                        upd_dirty = 1'b1;
                        state_d   = StWthru;
                    end else if (hit) begin
                        state_d = StHit;
                    end else if (lk_valid && lk_dirty) begin
                        state_d = StEvict;
                    end else begin
                        state_d = StFill;
                    end
                end else if (flush) begin
                    state_d = StFlush;
                end
            end
            StHit, StMerge: begin
                if (op_wr_q) begin
                    word_we   = 1'b1;
                    upd_en    = 1'b1;
                    upd_dirty = 1'b1;
                end else begin
                    data_load_d = cur_word;
                end
                if (state_q == StMerge && op_wt_q) begin
                    state_d = StWthru;
                end else begin
                    done_d  = 1'b1;
                    hit_d   = (state_q == StHit);
                    state_d = StIdle;
                end
            end
            StEvict: begin
                if (!mem_w_en_q && mem_ready) mem_w_en_d = 1'b1;
                if (mem_w_en_q && mem_done) begin
                    mem_w_en_d = 1'b0;
                    state_d    = StFill;
                end
            end
            StFill: begin
                if (!mem_r_en_q && mem_ready) mem_r_en_d = 1'b1;
                if (mem_r_en_q && mem_done) begin
                    mem_r_en_d = 1'b0;
                    line_we    = 1'b1;
                    upd_en     = 1'b1;
                    upd_valid  = 1'b1;
                    upd_dirty  = 1'b0;
                    upd_tag_en = 1'b1;
                    upd_tag    = req_tag;
                    state_d    = StMerge;
                end
            end
            StWthru, StFlWb: begin
                if (!mem_w_en_q && mem_ready) mem_w_en_d = 1'b1;
                if (mem_w_en_q && mem_done) begin
                    mem_w_en_d = 1'b0;
                    upd_en     = 1'b1;
                    upd_dirty  = 1'b0;
                    if (state_q == StWthru) begin
                        done_d  = 1'b1;
                        hit_d   = orig_hit_q;
                        state_d = StIdle;
                    end else begin
                        // Re-examine the now-clean line, which advances the counter.
                        state_d = StFlush;
                    end
                end
            end
            StFlush: begin
                if (lk_valid && lk_dirty) begin
                    state_d = StFlWb;
                end else if (flush_cnt_q == IDX_W'(NUM_LINES - 1)) begin
                    flush_cnt_d = '0;
                    done_d      = 1'b1;
                    state_d     = StIdle;
                end else begin
                    flush_cnt_d = flush_cnt_q + IDX_W'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            flush_cnt_q <= '0;
            done_q      <= 1'b0;
            hit_q       <= 1'b0;
            data_load_q <= '0;
            mem_r_en_q  <= 1'b0;
            mem_w_en_q  <= 1'b0;
            orig_hit_q  <= 1'b0;
            op_wr_q     <= 1'b0;
            op_wt_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            done_q      <= done_d;
            hit_q       <= hit_d;
            data_load_q <= data_load_d;
            mem_r_en_q  <= mem_r_en_d;
            mem_w_en_q  <= mem_w_en_d;
            orig_hit_q  <= orig_hit_d;
            op_wr_q     <= op_wr_d;
            op_wt_q     <= op_wt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (line_we) begin
            data_q[lk_idx] <= line_read;
        end else if (word_we) begin
            data_q[lk_idx][{req_off, 5'b0} +: 32] <= data_store;
        end
    end

    always_comb begin
        if (state_q == StFill) begin
            mem_addr = {req_tag, req_idx, {OFF_W{1'b0}}};
        end else begin
            mem_addr = {lk_tag, lk_idx, {OFF_W{1'b0}}};
        end
    end

    assign line_store = cur_line;
    assign data_load  = data_load_q;
    assign done       = done_q;
    assign cache_hit  = hit_q;
    assign mem_r_en   = mem_r_en_q;
    assign mem_w_en   = mem_w_en_q;

endmodule
